spi_slave_responder: RTL and testbench

//  SPI slave (responder): the far end of the SPI master link. Oversamples SCLK/CS_N/MOSI in the

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_slave_responder.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and types for the SPI responder
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int SYNC_STAGES        = 2;

  // SCLK idle level
  localparam bit CPOL_IDLE_LOW  = 1'b0;
  localparam bit CPOL_IDLE_HIGH = 1'b1;

  // Which SCLK edge samples MOSI
  localparam bit CPHA_LEAD_SAMPLE  = 1'b0;
  localparam bit CPHA_TRAIL_SAMPLE = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int STAGES    = SYNC_STAGES,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic in_clock,
  input  logic in_reset_n,
  input  logic in_async,
  output logic out_rise,
  output logic out_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              level;

  assign level = sync_q[STAGES-1];

  // Shift the asynchronous pin through the chain; remember the last synced value
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], in_async};
    prev_d = level;
  end

  // Synchronizer and history flops; reset to the pin's idle level
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign out_rise = level & ~prev_q;
  assign out_fall = ~level & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - oversampled SPI slave with one-word TX buffer
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit CPOL       = CPOL_IDLE_LOW,
  parameter bit CPHA       = CPHA_LEAD_SAMPLE
) (
  input  logic                  in_clock,
  input  logic                  in_reset_n,
  input  logic                  in_sclk,
  input  logic                  in_cs_n,
  input  logic                  in_mosi,
  output logic                  out_miso,
  output logic                  out_miso_oe,
  input  logic [DATA_WIDTH-1:0] in_tx_data,
  input  logic                  in_tx_valid,
  output logic                  out_tx_ready,
  output logic [DATA_WIDTH-1:0] out_rx_data,
  output logic                  out_rx_valid,
  output logic                  out_tx_underrun,
  output logic                  out_frame_err,
  output logic                  out_busy
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic mosi_s;
  logic do_load;
  logic [DATA_WIDTH-1:0] rx_word;

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_err_q, frame_err_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
    .in_clock  (in_clock),
    .in_reset_n(in_reset_n),
    .in_async  (in_sclk),
    .out_rise  (sclk_rise),
    .out_fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .in_clock  (in_clock),
    .in_reset_n(in_reset_n),
    .in_async  (in_cs_n),
    .out_rise  (cs_rise),
    .out_fall  (cs_fall)
  );

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Map raw SCLK edges onto leading/trailing and then onto sample/shift roles
  always_comb begin
    lead_edge   = (CPOL == CPOL_IDLE_HIGH) ? sclk_fall : sclk_rise;
    trail_edge  = (CPOL == CPOL_IDLE_HIGH) ? sclk_rise : sclk_fall;
    sample_edge = (CPHA == CPHA_LEAD_SAMPLE) ? lead_edge : trail_edge;
    shift_edge  = (CPHA == CPHA_TRAIL_SAMPLE) ? lead_edge : trail_edge;
  end

  // Next-state logic: frame FSM, bit counter, shift registers, TX buffer and pulses
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    tx_ready_d  = tx_ready_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], in_mosi};
    do_load     = 1'b0;
    rx_word     = {rx_shift_q, mosi_s};

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = '0;
          // With leading-edge sampling the first MSB must be on MISO before any SCLK edge
          if (CPHA == CPHA_LEAD_SAMPLE) begin
            do_load = 1'b1;
          end
        end
      end
      default: begin
        if (cs_rise) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          if (bit_cnt_q != '0) begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (sample_edge) begin
            rx_shift_d = rx_word[DATA_WIDTH-2:0];
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // A shift edge at a word boundary starts the next word instead of shifting
          if (shift_edge) begin
            if (bit_cnt_q == '0) begin
              do_load = 1'b1;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
      end
    endcase

    // Load uses the buffer as it stood before this cycle's handshake
    if (do_load) begin
      if (!tx_ready_q) begin
        tx_shift_d = tx_buf_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    if (in_tx_valid && tx_ready_q) begin
      tx_buf_d   = in_tx_data;
      tx_ready_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign out_busy        = (state_q == ST_ACTIVE);
  assign out_miso_oe     = (state_q == ST_ACTIVE);
  assign out_miso        = (state_q == ST_ACTIVE) & tx_shift_q[DATA_WIDTH-1];
  assign out_tx_ready    = tx_ready_q;
  assign out_rx_data     = rx_data_q;
  assign out_rx_valid    = rx_valid_q;
  assign out_tx_underrun = underrun_q;
  assign out_frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - directed bench for spi_slave_responder, modes 0 and 3
module tb_spi_slave_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sclk0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
  logic sclk1 = 1'b1, cs1 = 1'b1, mosi1 = 1'b0;
  logic [7:0] txd0 = 8'h00, txd1 = 8'h00;
  logic txv0 = 1'b0, txv1 = 1'b0;

  logic miso0, oe0, ready0, rxv_p0, unr_p0, fer_p0, busy0;
  logic miso1, oe1, ready1, rxv_p1, unr_p1, fer_p1, busy1;
  logic [7:0] rxd0, rxd1;

  int n_tests = 0;
  int n_fail = 0;
  int rxv0 = 0, unr0 = 0, fer0 = 0;
  int rxv1 = 0, unr1 = 0, fer1 = 0;

  spi_slave_responder #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .in_clock(clk), .in_reset_n(rst_n), .in_sclk(sclk0), .in_cs_n(cs0), .in_mosi(mosi0),
    .out_miso(miso0), .out_miso_oe(oe0), .in_tx_data(txd0), .in_tx_valid(txv0),
    .out_tx_ready(ready0), .out_rx_data(rxd0), .out_rx_valid(rxv_p0),
    .out_tx_underrun(unr_p0), .out_frame_err(fer_p0), .out_busy(busy0)
  );

  spi_slave_responder #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .in_clock(clk), .in_reset_n(rst_n), .in_sclk(sclk1), .in_cs_n(cs1), .in_mosi(mosi1),
    .out_miso(miso1), .out_miso_oe(oe1), .in_tx_data(txd1), .in_tx_valid(txv1),
    .out_tx_ready(ready1), .out_rx_data(rxd1), .out_rx_valid(rxv_p1),
    .out_tx_underrun(unr_p1), .out_frame_err(fer_p1), .out_busy(busy1)
  );

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rxv_p0) rxv0++;
    if (unr_p0) unr0++;
    if (fer_p0) fer0++;
    if (rxv_p1) rxv1++;
    if (unr_p1) unr1++;
    if (fer_p1) fer1++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_sclk(input int inst, input logic v);
    if (inst == 0) sclk0 = v; else sclk1 = v;
  endtask

  task automatic drive_mosi(input int inst, input logic v);
    if (inst == 0) mosi0 = v; else mosi1 = v;
  endtask

  task automatic drive_cs(input int inst, input logic v);
    if (inst == 0) cs0 = v; else cs1 = v;
  endtask

  function automatic logic miso_of(input int inst);
    return (inst == 0) ? miso0 : miso1;
  endfunction

  task automatic offer(input int inst, input logic [7:0] d);
    if (inst == 0) begin txd0 = d; txv0 = 1'b1; end
    else begin txd1 = d; txv1 = 1'b1; end
    cyc(1);
    txv0 = 1'b0;
    txv1 = 1'b0;
  endtask

  // Master side: inst 0 is mode 0, inst 1 is mode 3; half SCLK period = 4 clocks
  task automatic spi_bits(input int inst, input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    logic cpol;
    cpol = (inst == 1);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (inst == 0) begin
        drive_mosi(inst, mo[7-i]);
        cyc(4);
        mi[7-i] = miso_of(inst);
        drive_sclk(inst, ~cpol);
        cyc(4);
        drive_sclk(inst, cpol);
      end else begin
        drive_sclk(inst, ~cpol);
        drive_mosi(inst, mo[7-i]);
        cyc(4);
        mi[7-i] = miso_of(inst);
        drive_sclk(inst, cpol);
        cyc(4);
      end
    end
  endtask

  task automatic frame_start(input int inst);
    drive_cs(inst, 1'b0);
    cyc(4);
  endtask

  task automatic frame_end(input int inst);
    cyc(4);
    drive_cs(inst, 1'b1);
    cyc(6);
  endtask

  task automatic test_reset();
    logic [7:0] mi;
    int r0, u0, f0;
    n_tests++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL por_ready: got %b want 1", ready0); end
    n_tests++; if ({busy0, oe0, miso0, rxv_p0, rxd0} !== 12'h000) begin n_fail++; $display("FAIL por_outputs: got %b%b%b%b %h want all 0", busy0, oe0, miso0, rxv_p0, rxd0); end
    n_tests++; if ({busy1, oe1, miso1, ready1} !== 4'b0001) begin n_fail++; $display("FAIL por_mode3: got %b want 0001", {busy1, oe1, miso1, ready1}); end
    offer(0, 8'h12);
    n_tests++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL accept_ready_drop: got %b want 0", ready0); end
    frame_start(0);
    spi_bits(0, 8'hE0, 3, mi);
    n_tests++; if (busy0 !== 1'b1 || oe0 !== 1'b1) begin n_fail++; $display("FAIL busy_midframe: got %b%b want 11", busy0, oe0); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({busy0, oe0, miso0, rxv_p0, unr_p0, fer_p0} !== 6'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want 000000", {busy0, oe0, miso0, rxv_p0, unr_p0, fer_p0}); end
    n_tests++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready0); end
    n_tests++; if (rxd0 !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rxd0); end
    cs0 = 1'b1; sclk0 = 1'b0; mosi0 = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    r0 = rxv0; u0 = unr0; f0 = fer0;
    cyc(20);
    n_tests++; if ((rxv0 - r0) + (unr0 - u0) + (fer0 - f0) !== 0) begin n_fail++; $display("FAIL post_reset_pulses: got %0d want 0", (rxv0 - r0) + (unr0 - u0) + (fer0 - f0)); end
    n_tests++; if (ready0 !== 1'b1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_state: ready %b busy %b want 1 0", ready0, busy0); end
  endtask

  task automatic test_mode0_single();
    logic [7:0] mi;
    int r0;
    offer(0, 8'hA5);
    r0 = rxv0;
    frame_start(0);
    spi_bits(0, 8'h3C, 8, mi);
    frame_end(0);
    n_tests++; if (rxd0 !== 8'h3C) begin n_fail++; $display("FAIL single_rx_data: got %h want 3c", rxd0); end
    n_tests++; if (rxv0 - r0 !== 1) begin n_fail++; $display("FAIL single_rx_pulses: got %0d want 1", rxv0 - r0); end
    n_tests++; if (mi !== 8'hA5) begin n_fail++; $display("FAIL single_miso: got %h want a5", mi); end
    n_tests++; if ({busy0, oe0, miso0} !== 3'b000) begin n_fail++; $display("FAIL deselect_outputs: got %b want 000", {busy0, oe0, miso0}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    int r0;
    offer(0, 8'hA5);
    r0 = rxv0;
    frame_start(0);
    offer(0, 8'h5A);
    spi_bits(0, 8'h11, 8, mi1);
    n_tests++; if (rxd0 !== 8'h11) begin n_fail++; $display("FAIL b2b_rx_word1: got %h want 11", rxd0); end
    spi_bits(0, 8'h22, 8, mi2);
    frame_end(0);
    n_tests++; if (rxd0 !== 8'h22) begin n_fail++; $display("FAIL b2b_rx_word2: got %h want 22", rxd0); end
    n_tests++; if (rxv0 - r0 !== 2) begin n_fail++; $display("FAIL b2b_rx_pulses: got %0d want 2", rxv0 - r0); end
    n_tests++; if (mi1 !== 8'hA5 || mi2 !== 8'h5A) begin n_fail++; $display("FAIL b2b_miso: got %h %h want a5 5a", mi1, mi2); end
  endtask

  task automatic test_underrun();
    logic [7:0] mi1, mi2;
    int u0;
    n_tests++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL underrun_pre_ready: got %b want 1", ready0); end
    u0 = unr0;
    // CS fall is acted on 3 clocks after the pin moves; offer exactly on that cycle
    cs0 = 1'b0;
    cyc(2);
    offer(0, 8'h96);
    cyc(1);
    n_tests++; if (unr0 - u0 !== 1) begin n_fail++; $display("FAIL underrun_at_load: got %0d want 1", unr0 - u0); end
    n_tests++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL underrun_word_held: ready %b want 0", ready0); end
    spi_bits(0, 8'h44, 8, mi1);
    cyc(4);
    offer(0, 8'h33);
    spi_bits(0, 8'h55, 8, mi2);
    frame_end(0);
    n_tests++; if (mi1 !== 8'h00 || mi2 !== 8'h96) begin n_fail++; $display("FAIL underrun_miso: got %h %h want 00 96", mi1, mi2); end
    n_tests++; if (unr0 - u0 !== 1) begin n_fail++; $display("FAIL underrun_total: got %0d want 1", unr0 - u0); end
    n_tests++; if (rxd0 !== 8'h55) begin n_fail++; $display("FAIL underrun_rx: got %h want 55", rxd0); end
  endtask

  task automatic test_frame_err();
    logic [7:0] mi;
    int r0, f0;
    r0 = rxv0; f0 = fer0;
    frame_start(0);
    spi_bits(0, 8'hA0, 3, mi);
    frame_end(0);
    n_tests++; if (fer0 - f0 !== 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d want 1", fer0 - f0); end
    n_tests++; if (rxv0 - r0 !== 0) begin n_fail++; $display("FAIL frame_err_no_rx: got %0d want 0", rxv0 - r0); end
    n_tests++; if (rxd0 !== 8'h55) begin n_fail++; $display("FAIL frame_err_rx_held: got %h want 55", rxd0); end
    r0 = rxv0; f0 = fer0;
    frame_start(0);
    spi_bits(0, 8'hC3, 8, mi);
    frame_end(0);
    n_tests++; if (rxd0 !== 8'hC3 || rxv0 - r0 !== 1) begin n_fail++; $display("FAIL after_err_rx: got %h x%0d want c3 x1", rxd0, rxv0 - r0); end
    n_tests++; if (fer0 - f0 !== 0) begin n_fail++; $display("FAIL after_err_no_err: got %0d want 0", fer0 - f0); end
  endtask

  task automatic test_mode3();
    logic [7:0] mi;
    int r1, u1;
    offer(1, 8'h81);
    r1 = rxv1; u1 = unr1;
    frame_start(1);
    n_tests++; if (busy1 !== 1'b1 || oe1 !== 1'b1) begin n_fail++; $display("FAIL mode3_busy: got %b%b want 11", busy1, oe1); end
    spi_bits(1, 8'h7E, 8, mi);
    frame_end(1);
    n_tests++; if (mi !== 8'h81) begin n_fail++; $display("FAIL mode3_miso: got %h want 81", mi); end
    n_tests++; if (rxd1 !== 8'h7E || rxv1 - r1 !== 1) begin n_fail++; $display("FAIL mode3_rx: got %h x%0d want 7e x1", rxd1, rxv1 - r1); end
    n_tests++; if (unr1 - u1 !== 0) begin n_fail++; $display("FAIL mode3_underrun: got %0d want 0", unr1 - u1); end
    n_tests++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL mode3_ready: got %b want 1", ready1); end
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    test_reset();
    test_mode0_single();
    test_back_to_back();
    test_underrun();
    test_frame_err();
    test_mode3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
